// File: rtl/cache_mem_responder.sv
// rtl/cache_mem_responder.sv - line-granular main-memory model with fixed latency for cache refill/writeback
module cache_mem_responder #(
   parameter int LINE_ADDR_LEN = 3,
   parameter int MEM_ADDR_LEN  = 8,
   parameter int LATENCY       = 8
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               rd_req,
   input  logic                               wr_req,
   input  logic [MEM_ADDR_LEN-1:0]            addr,
   input  logic [32*(2**LINE_ADDR_LEN)-1:0]   wr_line,
   output logic [32*(2**LINE_ADDR_LEN)-1:0]   rd_line,
   output logic                               gnt,
   output logic                               busy,
   output logic [31:0]                        rd_count,
   output logic [31:0]                        wr_count
);

   localparam int LINE_W = 32 * (2**LINE_ADDR_LEN);
   localparam int DEPTH  = 2**MEM_ADDR_LEN;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t                    state, state_nx;
   logic [7:0]                cnt;
   logic                      op_wr;
   logic [MEM_ADDR_LEN-1:0]   addr_q;
   logic [LINE_W-1:0]         wline_q;
   logic                      accept, finish;

   logic [LINE_W-1:0]         mem [DEPTH] = '{default: '0};

   // Every request passes through BUSY so gnt lands LATENCY edges after accept.
   always_comb begin
      state_nx = state;
      accept   = 1'b0;
      finish   = 1'b0;
      case (state)
         IDLE: begin
            if (rd_req || wr_req) begin
               state_nx = BUSY;
               accept   = 1'b1;
            end
         end
         BUSY: begin
            if (cnt == 8'd0) begin
               state_nx = DONE;
               finish   = 1'b1;
            end
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   assign gnt  = (state == DONE);
   assign busy = (state != IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= 8'd0;
         op_wr    <= 1'b0;
         addr_q   <= '0;
         wline_q  <= '0;
         rd_line  <= '0;
         rd_count <= 32'd0;
         wr_count <= 32'd0;
      end else begin
         state <= state_nx;
         if (accept) begin
            op_wr   <= wr_req;
            addr_q  <= addr;
            wline_q <= wr_line;
            cnt     <= 8'(LATENCY - 1);
            if (wr_req)
               wr_count <= wr_count + 32'd1;
            else
               rd_count <= rd_count + 32'd1;
         end else if (state == BUSY && cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
         end
         if (finish && !op_wr)
            rd_line <= mem[addr_q];
      end
   end

   // Storage has no reset; finish is never set while rst holds the FSM in IDLE.
   always_ff @(posedge clk) begin
      if (finish && op_wr)
         mem[addr_q] <= wline_q;
   end

endmodule
